execute_md: RTL and testbench

//  Execute stage with an iterative multiply unit and architectural HI/LO registers. Sits between decode and memory.

---
 rtl/execute_md.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_execute_md.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_md.sv
// execute_md: execute stage with single-cycle ALU, architectural HI/LO
// registers and a background iterative multiplier (MUL_STEP bits/cycle).
// Optional restoring divider is built only when EXECUTE_MD_DIV_EN is defined;
// otherwise DIV/DIVU behave as NONE.
// ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU,
//              8 SLL, 9 SRL, 10 SRA, 11 LUI (b[15:0] << 16), others -> 0.
module execute_md #(
    parameter int unsigned MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_id_ex,
    input  logic        flush_id_ex,
    input  logic        mem_stall,
    input  logic [3:0]  alu_op_id_ex,
    input  logic        alu_sel_id_ex,
    input  logic [3:0]  md_op_id_ex,
    input  logic [31:0] imm_id_ex,
    input  logic [31:0] rs_data_id_ex,
    input  logic [31:0] rt_data_id_ex,
    input  logic        mem_en_id_ex,
    input  logic        rd_en_id_ex,
    input  logic        rd_data_sel_id_ex,
    input  logic [4:0]  rd_addr_id_ex,
    output logic        stall_ex_id,
    output logic        valid_ex_mem,
    output logic [31:0] alu_data_ex_mem,
    output logic [31:0] rt_data_ex_mem,
    output logic        rd_en_ex_mem,
    output logic        mem_en_ex_mem,
    output logic        rd_data_sel_ex_mem,
    output logic [4:0]  rd_addr_ex_mem,
    output logic        md_busy
);

    localparam int unsigned N = 32 / MUL_STEP;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_MFHI  = 4'd3,
        MD_MFLO  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_DIV   = 4'd8,
        MD_DIVU  = 4'd9
    } md_op_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

`ifdef EXECUTE_MD_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

    state_t      r_state;
    logic        r_busy;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic        r_sign;

    logic        r_valid;
    logic [31:0] r_alu_data;
    logic [31:0] r_rt_data;
    logic        r_rd_en;
    logic        r_mem_en;
    logic        r_rd_sel;
    logic [4:0]  r_rd_addr;

    logic        w_is_mul;
    logic        w_is_mul_signed;
    logic        w_is_div;
    logic        w_is_div_signed;
    logic        w_hilo_op;
    logic        w_rd_block;
    logic        w_interlock;
    logic        w_accept;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic [31:0] w_ex_data;
    logic [31:0] w_rs_abs;
    logic [31:0] w_rt_abs;
    logic        w_mul_sign;
    logic [63:0] w_acc_next;
    logic [63:0] w_product;

`ifdef EXECUTE_MD_DIV_EN
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic [31:0] r_dvnd_raw;
    logic        r_div_zero;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
`endif

    // Decode the multiply/divide opcode and derive interlock/accept.
    always_comb begin
        w_is_mul        = (md_op_id_ex == MD_MULT) || (md_op_id_ex == MD_MULTU);
        w_is_mul_signed = (md_op_id_ex == MD_MULT);
`ifdef EXECUTE_MD_DIV_EN
        w_is_div        = (md_op_id_ex == MD_DIV) || (md_op_id_ex == MD_DIVU);
        w_is_div_signed = (md_op_id_ex == MD_DIV);
`else
        w_is_div        = 1'b0;
        w_is_div_signed = 1'b0;
`endif
        w_rd_block  = w_is_mul || w_is_div ||
                      (md_op_id_ex == MD_MTHI) || (md_op_id_ex == MD_MTLO);
        w_hilo_op   = w_rd_block ||
                      (md_op_id_ex == MD_MFHI) || (md_op_id_ex == MD_MFLO);
        w_interlock = valid_id_ex & ~flush_id_ex & w_hilo_op & r_busy;
        w_accept    = valid_id_ex & ~flush_id_ex & ~mem_stall & ~w_interlock;
        stall_ex_id = mem_stall | w_interlock;
    end

    // Single-cycle ALU and selection of the value forwarded to memory.
    always_comb begin
        w_alu_b   = alu_sel_id_ex ? imm_id_ex : rt_data_id_ex;
        w_alu_res = '0;
        case (alu_op_id_ex)
            ALU_ADD:  w_alu_res = rs_data_id_ex + w_alu_b;
            ALU_SUB:  w_alu_res = rs_data_id_ex - w_alu_b;
            ALU_AND:  w_alu_res = rs_data_id_ex & w_alu_b;
            ALU_OR:   w_alu_res = rs_data_id_ex | w_alu_b;
            ALU_XOR:  w_alu_res = rs_data_id_ex ^ w_alu_b;
            ALU_NOR:  w_alu_res = ~(rs_data_id_ex | w_alu_b);
            ALU_SLT:  w_alu_res = {31'd0, $signed(rs_data_id_ex) < $signed(w_alu_b)};
            ALU_SLTU: w_alu_res = {31'd0, rs_data_id_ex < w_alu_b};
            ALU_SLL:  w_alu_res = rs_data_id_ex << w_alu_b[4:0];
            ALU_SRL:  w_alu_res = rs_data_id_ex >> w_alu_b[4:0];
            ALU_SRA:  w_alu_res = $unsigned($signed(rs_data_id_ex) >>> w_alu_b[4:0]);
            ALU_LUI:  w_alu_res = {w_alu_b[15:0], 16'd0};
            default:  w_alu_res = '0;
        endcase
        if (md_op_id_ex == MD_MFHI)
            w_ex_data = r_hi;
        else if (md_op_id_ex == MD_MFLO)
            w_ex_data = r_lo;
        else
            w_ex_data = w_alu_res;
    end

    // Operand magnitudes and result sign for a starting multiply/divide.
    always_comb begin
        w_rs_abs   = ((w_is_mul_signed || w_is_div_signed) && rs_data_id_ex[31]) ?
                     (~rs_data_id_ex + 32'd1) : rs_data_id_ex;
        w_rt_abs   = ((w_is_mul_signed || w_is_div_signed) && rt_data_id_ex[31]) ?
                     (~rt_data_id_ex + 32'd1) : rt_data_id_ex;
        w_mul_sign = w_is_mul_signed & (rs_data_id_ex[31] ^ rt_data_id_ex[31]);
    end

    // Shift-add step: retire MUL_STEP multiplier bits into the accumulator.
    always_comb begin
        w_acc_next = r_acc;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (r_mplier[j[4:0]])
                w_acc_next = w_acc_next + (r_mcand << j);
        end
        w_product = r_sign ? (~w_acc_next + 64'd1) : w_acc_next;
    end

`ifdef EXECUTE_MD_DIV_EN
    // Restoring divide step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_shift    = {r_rem, r_quo[31]};
        w_ge       = (w_shift >= {1'b0, r_dvsr});
        w_sub      = w_shift - {1'b0, r_dvsr};
        w_rem_next = w_ge ? w_sub[31:0] : w_shift[31:0];
        w_quo_next = {r_quo[30:0], w_ge};
    end
`endif

    // Multiply/divide FSM with HI/LO and the registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
`ifdef EXECUTE_MD_DIV_EN
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_dvnd_raw <= '0;
            r_div_zero <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state  <= S_MUL;
                        r_busy   <= 1'b1;
                        r_cnt    <= 6'(N);
                        r_acc    <= '0;
                        r_mcand  <= {32'd0, w_rs_abs};
                        r_mplier <= w_rt_abs;
                        r_sign   <= w_mul_sign;
`ifdef EXECUTE_MD_DIV_EN
                    end else if (w_accept && w_is_div) begin
                        r_state    <= S_DIV;
                        r_busy     <= 1'b1;
                        r_cnt      <= 6'd32;
                        r_rem      <= '0;
                        r_quo      <= w_rs_abs;
                        r_dvsr     <= w_rt_abs;
                        r_dvnd_raw <= rs_data_id_ex;
                        r_div_zero <= (rt_data_id_ex == 32'd0);
                        r_q_neg    <= w_is_div_signed & (rs_data_id_ex[31] ^ rt_data_id_ex[31]);
                        r_r_neg    <= w_is_div_signed & rs_data_id_ex[31];
`endif
                    end else if (w_accept && (md_op_id_ex == MD_MTHI)) begin
                        r_hi <= rs_data_id_ex;
                    end else if (w_accept && (md_op_id_ex == MD_MTLO)) begin
                        r_lo <= rs_data_id_ex;
                    end
                end
                S_MUL: begin
                    r_cnt    <= r_cnt - 6'd1;
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << MUL_STEP;
                    r_mplier <= r_mplier >> MUL_STEP;
                    if (r_cnt == 6'd1) begin
                        {r_hi, r_lo} <= w_product;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
`ifdef EXECUTE_MD_DIV_EN
                S_DIV: begin
                    r_cnt <= r_cnt - 6'd1;
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_cnt == 6'd1) begin
                        if (r_div_zero) begin
                            r_lo <= '1;
                            r_hi <= r_dvnd_raw;
                        end else begin
                            r_lo <= r_q_neg ? (~w_quo_next + 32'd1) : w_quo_next;
                            r_hi <= r_r_neg ? (~w_rem_next + 32'd1) : w_rem_next;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Ex->mem pipeline register: hold on mem_stall, bubble when nothing accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_alu_data <= '0;
            r_rt_data  <= '0;
            r_rd_en    <= 1'b0;
            r_mem_en   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_rd_addr  <= '0;
        end else if (!mem_stall) begin
            if (w_accept) begin
                r_valid    <= 1'b1;
                r_alu_data <= w_ex_data;
                r_rt_data  <= rt_data_id_ex;
                r_rd_en    <= rd_en_id_ex & ~w_rd_block;
                r_mem_en   <= mem_en_id_ex;
                r_rd_sel   <= rd_data_sel_id_ex;
                r_rd_addr  <= rd_addr_id_ex;
            end else begin
                r_valid  <= 1'b0;
                r_rd_en  <= 1'b0;
                r_mem_en <= 1'b0;
            end
        end
    end

    assign valid_ex_mem       = r_valid;
    assign alu_data_ex_mem    = r_alu_data;
    assign rt_data_ex_mem     = r_rt_data;
    assign rd_en_ex_mem       = r_rd_en;
    assign mem_en_ex_mem      = r_mem_en;
    assign rd_data_sel_ex_mem = r_rd_sel;
    assign rd_addr_ex_mem     = r_rd_addr;
    assign md_busy            = r_busy;

endmodule

// File: tb/tb_execute_md.sv
// Testbench for execute_md: cycle model of the stage plus directed vectors.
module tb_execute_md;

    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                           OP_MFHI = 4'd3, OP_MFLO = 4'd4, OP_MTHI = 4'd5,
                           OP_MTLO = 4'd6, OP_DIV = 4'd8, OP_DIVU = 4'd9;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd6, A_SLTU = 4'd7,
                           A_SRA = 4'd10, A_LUI = 4'd11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, valid = 1'b0, flush = 1'b0, mstall = 1'b0;
    logic [3:0]  alu_op = '0, md_op = '0;
    logic        alu_sel = 1'b0, mem_en = 1'b0, rd_en = 1'b0, rd_sel = 1'b0;
    logic [31:0] imm = '0, rs = '0, rt = '0;
    logic [4:0]  rd_addr = '0;
    logic        stall_o, valid_o, rden_o, memen_o, rdsel_o, busy_o;
    logic [31:0] data_o, rt_o;
    logic [4:0]  addr_o;

    execute_md #(.MUL_STEP(1)) dut (
        .clk(clk), .rst(rst), .valid_id_ex(valid), .flush_id_ex(flush),
        .mem_stall(mstall), .alu_op_id_ex(alu_op), .alu_sel_id_ex(alu_sel),
        .md_op_id_ex(md_op), .imm_id_ex(imm), .rs_data_id_ex(rs),
        .rt_data_id_ex(rt), .mem_en_id_ex(mem_en), .rd_en_id_ex(rd_en),
        .rd_data_sel_id_ex(rd_sel), .rd_addr_id_ex(rd_addr),
        .stall_ex_id(stall_o), .valid_ex_mem(valid_o), .alu_data_ex_mem(data_o),
        .rt_data_ex_mem(rt_o), .rd_en_ex_mem(rden_o), .mem_en_ex_mem(memen_o),
        .rd_data_sel_ex_mem(rdsel_o), .rd_addr_ex_mem(addr_o), .md_busy(busy_o)
    );

    // Second instance with a 4-bit multiply step, driven independently.
    logic        v4 = 1'b0;
    logic [3:0]  md4 = '0;
    logic [31:0] rs4 = '0, rt4 = '0;
    logic        stall4, valid4, rden4, memen4, rdsel4, busy4;
    logic [31:0] data4, rto4;
    logic [4:0]  addr4;

    execute_md #(.MUL_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .valid_id_ex(v4), .flush_id_ex(1'b0),
        .mem_stall(1'b0), .alu_op_id_ex(4'd0), .alu_sel_id_ex(1'b0),
        .md_op_id_ex(md4), .imm_id_ex(32'd0), .rs_data_id_ex(rs4),
        .rt_data_id_ex(rt4), .mem_en_id_ex(1'b0), .rd_en_id_ex(1'b0),
        .rd_data_sel_id_ex(1'b0), .rd_addr_id_ex(5'd0),
        .stall_ex_id(stall4), .valid_ex_mem(valid4), .alu_data_ex_mem(data4),
        .rt_data_ex_mem(rto4), .rd_en_ex_mem(rden4), .mem_en_ex_mem(memen4),
        .rd_data_sel_ex_mem(rdsel4), .rd_addr_ex_mem(addr4), .md_busy(busy4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return a << b[4:0];
            4'd9:  return a >> b[4:0];
            4'd10: return $unsigned($signed(a) >>> b[4:0]);
            4'd11: return {b[15:0], 16'd0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit div_on();
`ifdef EXECUTE_MD_DIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit writes_hilo(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MTHI) || (op == OP_MTLO) ||
               (div_on() && ((op == OP_DIV) || (op == OP_DIVU)));
    endfunction

    function automatic bit is_hilo(input logic [3:0] op);
        return writes_hilo(op) || (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

    // Behavioural model: HI/LO, remaining busy cycles, pending result, ex->mem fields.
    logic [31:0] m_hi = '0, m_lo = '0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic        e_valid = 0, e_rden = 0, e_memen = 0, e_sel = 0;
    logic [31:0] e_data = '0, e_rt = '0;
    logic [4:0]  e_addr = '0;

    always @(negedge clk) begin
        logic inter;
        logic [31:0] old_hi, old_lo;
        logic [63:0] q, r;
        inter = valid && !flush && is_hilo(md_op) && (m_left > 0);
        check("stall_ex_id", {63'd0, stall_o}, {63'd0, mstall | inter});
        check("md_busy", {63'd0, busy_o}, {63'd0, m_left > 0});
        check("valid_ex_mem", {63'd0, valid_o}, {63'd0, e_valid});
        check("rd_en_ex_mem", {63'd0, rden_o}, {63'd0, e_rden});
        check("mem_en_ex_mem", {63'd0, memen_o}, {63'd0, e_memen});
        if (e_valid) begin
            check("alu_data_ex_mem", {32'd0, data_o}, {32'd0, e_data});
            check("rt_data_ex_mem", {32'd0, rt_o}, {32'd0, e_rt});
            check("rd_sel/addr", {58'd0, rdsel_o, addr_o}, {58'd0, e_sel, e_addr});
        end
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_pend = '0;
            e_valid = 0; e_rden = 0; e_memen = 0; e_sel = 0;
            e_data = '0; e_rt = '0; e_addr = '0;
        end else begin
            old_hi = m_hi; old_lo = m_lo;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) {m_hi, m_lo} = m_pend;
            end
            if (!mstall) begin
                if (valid && !flush && !inter) begin
                    e_valid = 1;
                    e_data  = (md_op == OP_MFHI) ? old_hi :
                              (md_op == OP_MFLO) ? old_lo : alu_f(alu_op, rs, alu_sel ? imm : rt);
                    e_rt = rt; e_rden = rd_en && !writes_hilo(md_op);
                    e_memen = mem_en; e_sel = rd_sel; e_addr = rd_addr;
                    case (md_op)
                        OP_MULT: begin
                            m_left = 32;
                            m_pend = longint'($signed(rs)) * longint'($signed(rt));
                        end
                        OP_MULTU: begin
                            m_left = 32;
                            m_pend = {32'd0, rs} * {32'd0, rt};
                        end
                        OP_MTHI: m_hi = rs;
                        OP_MTLO: m_lo = rs;
                        OP_DIV, OP_DIVU: if (div_on()) begin
                            m_left = 32;
                            if (rt == 0) m_pend = {rs, 32'hFFFFFFFF};
                            else if (md_op == OP_DIV) begin
                                q = longint'($signed(rs)) / longint'($signed(rt));
                                r = longint'($signed(rs)) % longint'($signed(rt));
                                m_pend = {r[31:0], q[31:0]};
                            end else
                                m_pend = {rs % rt, rs / rt};
                        end
                        default: ;
                    endcase
                end else begin
                    e_valid = 0; e_rden = 0; e_memen = 0;
                end
            end
        end
    end

    // Present one instruction, wait (bounded) until accepted, return its ex->mem data.
    task automatic issue(input logic [3:0] aop, input logic sel, input logic [3:0] mop,
                         input logic [31:0] i_imm, input logic [31:0] i_rs,
                         input logic [31:0] i_rt, output logic [31:0] res, output int stalls);
        alu_op = aop; alu_sel = sel; md_op = mop; imm = i_imm; rs = i_rs; rt = i_rt;
        rd_en = 1'b1; rd_addr = 5'(i_rs); mem_en = 1'b0; rd_sel = i_rs[0]; valid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
            if (stalls > 200) begin
                check("issue wait budget", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        res = data_o;
        valid = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int st, cnt;

        repeat (2) @(posedge clk); #1;
        check("reset valid_ex_mem", {63'd0, valid_o}, 64'd0);
        check("reset alu_data", {32'd0, data_o}, 64'd0);
        check("reset md_busy", {62'd0, busy_o, busy4}, 64'd0);
        rst = 1'b0;

        // plain ALU vectors
        issue(A_SUB, 0, OP_NONE, 0, 32'd10, 32'd3, res, st);  check("SUB", {32'd0, res}, 64'd7);
        issue(A_SLT, 0, OP_NONE, 0, 32'hFFFFFFFF, 1, res, st); check("SLT", {32'd0, res}, 64'd1);
        issue(A_SLTU, 0, OP_NONE, 0, 32'hFFFFFFFF, 1, res, st); check("SLTU", {32'd0, res}, 64'd0);
        issue(A_LUI, 1, OP_NONE, 32'h1234, 0, 0, res, st);    check("LUI", {32'd0, res}, 64'h12340000);
        issue(A_SRA, 1, OP_NONE, 32'd4, 32'h80000000, 0, res, st);
        check("SRA", {32'd0, res}, 64'hF8000000);
        issue(A_ADD, 0, OP_MTHI, 0, 32'hCAFE0001, 0, res, st);
        issue(A_ADD, 0, OP_MFHI, 0, 0, 0, res, st);           check("MTHI->MFHI", {32'd0, res}, 64'hCAFE0001);

        // MULT 7 * -3
        issue(A_ADD, 0, OP_MULT, 0, 32'd7, 32'hFFFFFFFD, res, st);
        issue(A_ADD, 0, OP_MFHI, 0, 0, 0, res, st);
        check("MULT stall cycles", 64'(st), 64'd32);
        check("MULT HI", {32'd0, res}, 64'hFFFFFFFF);
        issue(A_ADD, 0, OP_MFLO, 0, 0, 0, res, st);
        check("MULT LO", {32'd0, res}, 64'hFFFFFFEB);

        // MULTU all-ones
        issue(A_ADD, 0, OP_MULTU, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, res, st);
        issue(A_ADD, 0, OP_MFHI, 0, 0, 0, res, st);
        check("MULTU busy cycles", 64'(st), 64'd32);
        check("MULTU HI", {32'd0, res}, 64'hFFFFFFFE);
        issue(A_ADD, 0, OP_MFLO, 0, 0, 0, res, st);
        check("MULTU LO", {32'd0, res}, 64'h00000001);

        // MULT with five independent ADDs flowing behind it
        issue(A_ADD, 0, OP_MULT, 0, 32'hFFFFFFFB, 32'hFFFFFFFA, res, st);
        for (int i = 0; i < 5; i++) begin
            issue(A_ADD, 1, OP_NONE, 32'd100, 32'(i), 0, res, st);
            check("ADD behind MULT no stall", 64'(st), 64'd0);
            check("ADD behind MULT data", {32'd0, res}, 64'(100 + i));
        end
        issue(A_ADD, 0, OP_MFLO, 0, 0, 0, res, st);
        check("MFLO after ADDs stall", 64'(st), 64'd27);
        check("MFLO after ADDs data", {32'd0, res}, 64'd30);

        // mem_stall holding a live ADD
        issue(A_ADD, 1, OP_NONE, 32'd1, 32'd1, 0, res, st);
        alu_op = A_ADD; alu_sel = 1; md_op = OP_NONE; imm = 5; rs = 5; valid = 1; mstall = 1;
        repeat (2) @(posedge clk); #1;
        check("held ADD under mem_stall", {32'd0, data_o}, 64'd2);
        mstall = 0;
        @(posedge clk); #1; valid = 0;
        check("ADD after mem_stall", {32'd0, data_o}, 64'd10);

        // mem_stall for 3 cycles during an MFLO interlock
        issue(A_ADD, 0, OP_MULT, 0, 32'd3, 32'd4, res, st);
        alu_op = A_ADD; alu_sel = 0; md_op = OP_MFLO; rs = 0; rt = 0; valid = 1;
        repeat (5) @(posedge clk); #1; mstall = 1;
        repeat (3) @(posedge clk); #1; mstall = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!stall_o) break;
            cnt++;
            if (cnt > 100) begin check("MFLO interlock budget", 64'd1, 64'd0); break; end
        end
        @(posedge clk); #1; valid = 0;
        check("MFLO across mem_stall", {32'd0, data_o}, 64'd12);

`ifdef EXECUTE_MD_DIV_EN
        issue(A_ADD, 0, OP_DIV, 0, 32'hFFFFFFF9, 32'd2, res, st);
        issue(A_ADD, 0, OP_MFLO, 0, 0, 0, res, st);
        check("DIV busy cycles", 64'(st), 64'd32);
        check("DIV LO", {32'd0, res}, 64'hFFFFFFFD);
        issue(A_ADD, 0, OP_MFHI, 0, 0, 0, res, st);
        check("DIV HI", {32'd0, res}, 64'hFFFFFFFF);
        issue(A_ADD, 0, OP_DIVU, 0, 32'd9, 32'd0, res, st);
        issue(A_ADD, 0, OP_MFLO, 0, 0, 0, res, st);
        check("DIVU/0 busy cycles", 64'(st), 64'd32);
        check("DIVU/0 LO", {32'd0, res}, 64'hFFFFFFFF);
        issue(A_ADD, 0, OP_MFHI, 0, 0, 0, res, st);
        check("DIVU/0 HI", {32'd0, res}, 64'd9);
`else
        issue(A_ADD, 0, OP_DIV, 0, 32'hFFFFFFF9, 32'd2, res, st);
        issue(A_ADD, 0, OP_MFLO, 0, 0, 0, res, st);
        check("DIV disabled no stall", 64'(st), 64'd0);
        check("DIV disabled LO kept", {32'd0, res}, 64'd12);
`endif

        // MUL_STEP=4 instance
        @(posedge clk); #1;
        v4 = 1; md4 = OP_MULTU; rs4 = 32'hFFFFFFFF; rt4 = 32'hFFFFFFFF;
        @(posedge clk); #1; v4 = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!busy4) break;
            cnt++;
            if (cnt > 100) begin check("step4 busy budget", 64'd1, 64'd0); break; end
        end
        check("step4 busy cycles", 64'(cnt), 64'd8);
        @(posedge clk); #1; v4 = 1; md4 = OP_MFHI;
        @(posedge clk); #1; md4 = OP_MFLO;
        check("step4 HI", {32'd0, data4}, 64'hFFFFFFFE);
        @(posedge clk); #1; v4 = 0;
        check("step4 LO", {32'd0, data4}, 64'h00000001);

        // flushed MULT is a bubble and starts nothing
        alu_op = A_ADD; md_op = OP_MULT; rs = 9; rt = 9; valid = 1; flush = 1;
        @(posedge clk); #1; valid = 0; flush = 0;
        check("flushed MULT busy", {63'd0, busy_o}, 64'd0);
        check("flushed MULT valid", {63'd0, valid_o}, 64'd0);

        // reset mid-multiply
        issue(A_ADD, 0, OP_MULT, 0, 32'd9, 32'd9, res, st);
        repeat (10) @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        check("reset mid-MULT busy", {63'd0, busy_o}, 64'd0);
        check("reset mid-MULT valid", {63'd0, valid_o}, 64'd0);
        issue(A_ADD, 0, OP_MFHI, 0, 0, 0, res, st);
        check("HI after reset", {32'd0, res}, 64'd0);
        check("no stall after reset", 64'(st), 64'd0);
        issue(A_ADD, 0, OP_MFLO, 0, 0, 0, res, st);
        check("LO after reset", {32'd0, res}, 64'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
